vga_pixel_driver: RTL and testbench

VGA_PIXEL_DRIVER -- requirements
Module: vga_pixel_driver

---
 rtl/vga_pixel_driver.sv | 177 +++++++++++++++++
 tb/tb_vga_pixel_driver.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_driver.sv
// VGA timing generator and pixel output stage: free-running h/v counters, 2-stage aligned syncs/blanking, RRRGGGBB to 8-bit DAC expansion.
// Optional colour-bar generator enabled by defining VGA_TEST_PATTERN_EN (selected at run time by testMode).
module vga_pixel_driver #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  RGBIn,
    input  logic        testMode,
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        startOfFrame,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        hSync,
    output logic        vSync,
    output logic        blankN
);

    localparam logic [10:0] H_LAST    = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] V_LAST    = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);

    // 3-bit channels replicate their MSBs so full scale reaches 8'hFF exactly.
    function automatic logic [23:0] expand_rgb(input logic [7:0] rgb);
        expand_rgb = {rgb[7:5], rgb[7:5], rgb[7:6],
                      rgb[4:2], rgb[4:2], rgb[4:3],
                      rgb[1:0], rgb[1:0], rgb[1:0], rgb[1:0]};
    endfunction

    logic [10:0] h_count_q, h_count_d;
    logic [10:0] v_count_q, v_count_d;
    logic        active_s1_q, active_s1_d;
    logic        hsync_s1_q, hsync_s1_d;
    logic        vsync_s1_q, vsync_s1_d;
    logic [7:0]  red_q, red_d;
    logic [7:0]  green_q, green_d;
    logic [7:0]  blue_q, blue_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        blank_n_q, blank_n_d;
    logic [7:0]  rgb_src_s;
    logic [23:0] rgb_dac_s;

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [10:0] BAR_W = 11'(H_ACTIVE / 8);

    // Bar order: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic logic [7:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_color = 8'hFF;
            3'd1:    bar_color = 8'hFC;
            3'd2:    bar_color = 8'h1F;
            3'd3:    bar_color = 8'h1C;
            3'd4:    bar_color = 8'hE3;
            3'd5:    bar_color = 8'hE0;
            3'd6:    bar_color = 8'h03;
            default: bar_color = 8'h00;
        endcase
    endfunction

    logic [10:0] x_s1_q, x_s1_d;
    logic [10:0] bar_num_s;
    logic [2:0]  bar_idx_s;
`else
    logic unused_test_mode_s;
    assign unused_test_mode_s = testMode;
`endif

    // Counter advance and stage-0 timing decode.
    always_comb begin
        h_count_d = h_count_q + 11'd1;
        v_count_d = v_count_q;
        if (h_count_q == H_LAST) begin
            h_count_d = 11'd0;
            if (v_count_q == V_LAST) begin
                v_count_d = 11'd0;
            end else begin
                v_count_d = v_count_q + 11'd1;
            end
        end else begin
            v_count_d = v_count_q;
        end
        active_s1_d = (h_count_q < H_ACT_END) && (v_count_q < V_ACT_END);
        hsync_s1_d  = !((h_count_q >= HS_START) && (h_count_q < HS_END));
        vsync_s1_d  = !((v_count_q >= VS_START) && (v_count_q < VS_END));
`ifdef VGA_TEST_PATTERN_EN
        x_s1_d = h_count_q;
`endif
    end

    // Output stage: pick the pixel source, expand to DAC width and blank.
    always_comb begin
        rgb_src_s = RGBIn;
`ifdef VGA_TEST_PATTERN_EN
        bar_num_s = x_s1_q / BAR_W;
        if (bar_num_s > 11'd7) begin
            bar_idx_s = 3'd7;
        end else begin
            bar_idx_s = bar_num_s[2:0];
        end
        if (testMode) begin
            rgb_src_s = bar_color(bar_idx_s);
        end else begin
            rgb_src_s = RGBIn;
        end
`endif
        rgb_dac_s = expand_rgb(rgb_src_s);
        if (active_s1_q) begin
            {red_d, green_d, blue_d} = rgb_dac_s;
        end else begin
            {red_d, green_d, blue_d} = 24'h000000;
        end
        hsync_d   = hsync_s1_q;
        vsync_d   = vsync_s1_q;
        blank_n_d = active_s1_q;
    end

    // State update; reset also flushes the pipeline so no stale pixels escape.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_count_q   <= 11'd0;
            v_count_q   <= 11'd0;
            active_s1_q <= 1'b0;
            hsync_s1_q  <= 1'b1;
            vsync_s1_q  <= 1'b1;
            red_q       <= 8'h00;
            green_q     <= 8'h00;
            blue_q      <= 8'h00;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            blank_n_q   <= 1'b0;
`ifdef VGA_TEST_PATTERN_EN
            x_s1_q      <= 11'd0;
`endif
        end else begin
            h_count_q   <= h_count_d;
            v_count_q   <= v_count_d;
            active_s1_q <= active_s1_d;
            hsync_s1_q  <= hsync_s1_d;
            vsync_s1_q  <= vsync_s1_d;
            red_q       <= red_d;
            green_q     <= green_d;
            blue_q      <= blue_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            blank_n_q   <= blank_n_d;
`ifdef VGA_TEST_PATTERN_EN
            x_s1_q      <= x_s1_d;
`endif
        end
    end

    assign pixelX       = h_count_q;
    assign pixelY       = v_count_q;
    assign startOfFrame = (h_count_q == 11'd0) && (v_count_q == 11'd0);
    assign red          = red_q;
    assign green        = green_q;
    assign blue         = blue_q;
    assign hSync        = hsync_q;
    assign vSync        = vsync_q;
    assign blankN       = blank_n_q;

endmodule

// File: tb/tb_vga_pixel_driver.sv
// Scoreboard bench for vga_pixel_driver using a reduced raster (92x21) so several frames fit in a short run.
module tb_vga_pixel_driver;

    localparam int HA = 64, HF = 8, HS = 12, HB = 8;
    localparam int VA = 12, VF = 3, VS = 2, VB = 4;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
`ifdef VGA_TEST_PATTERN_EN
    localparam bit TP_EN = 1'b1;
`else
    localparam bit TP_EN = 1'b0;
`endif
    localparam logic [23:0] BAR_DAC [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    typedef struct {
        logic [7:0] r, g, b;
        logic       hs, vs, bn, tm;
        int         h, v;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rgb_in;
    logic        test_mode;
    logic [10:0] pixel_x, pixel_y;
    logic        sof;
    logic [7:0]  red, green, blue;
    logic        h_sync, v_sync, blank_n;

    exp_t q[$];
    int   checks = 0, passes = 0, cyc = 0;
    int   mh = 0, mv = 0, mode = 0;
    bit   armed = 1'b0;
    bit   prev_hs = 1'b1, prev_vs = 1'b1;
    int   last_h0 = -1, last_sof = -1;
    int   vs_low_cnt = 0, sof_cnt = 0, red_hit_cnt = 0;

    vga_pixel_driver #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk), .reset(reset), .RGBIn(rgb_in), .testMode(test_mode),
        .pixelX(pixel_x), .pixelY(pixel_y), .startOfFrame(sof),
        .red(red), .green(green), .blue(blue),
        .hSync(h_sync), .vSync(v_sync), .blankN(blank_n)
    );

    always #20 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, got, want, cyc);
    endtask

    function automatic logic [7:0] exp3(input logic [2:0] c);
        logic [7:0] o;
        o = {c, c, c[2:1]};
        return o;
    endfunction

    function automatic logic [7:0] pattern(input int h);
        case (mode)
            0:       return 8'hFF;
            1:       return (h == 10) ? 8'hE0 : 8'h00;
            default: return 8'($urandom);
        endcase
    endfunction

    function automatic exp_t expect_px(input int h, input int v, input logic [7:0] rgb, input logic tm);
        exp_t e;
        logic act;
        logic [23:0] dac;
        act = (h < HA) && (v < VA);
        dac = {exp3(rgb[7:5]), exp3(rgb[4:2]), {4{rgb[1:0]}}};
        if (act && tm && TP_EN) dac = BAR_DAC[h / (HA / 8)];
        if (!act) dac = 24'h000000;
        e.r = dac[23:16]; e.g = dac[15:8]; e.b = dac[7:0];
        e.hs = !((h >= HA + HF) && (h < HA + HF + HS));
        e.vs = !((v >= VA + VF) && (v < VA + VF + VS));
        e.bn = act; e.tm = tm; e.h = h; e.v = v;
        return e;
    endfunction

    function automatic exp_t idle_px();
        exp_t e;
        e.r = 8'h00; e.g = 8'h00; e.b = 8'h00;
        e.hs = 1'b1; e.vs = 1'b1; e.bn = 1'b0; e.tm = 1'b0; e.h = -1; e.v = -1;
        return e;
    endfunction

    // One pixel clock: sample/compare at negedge, push expectation, apply reset, then drive the upstream-registered RGB.
    task automatic cycle(input logic rst_next);
        exp_t e;
        logic [7:0] rgb_nx;
        @(negedge clk);
        cyc++;
        if (armed) begin
            check_val("pixelX", 32'(pixel_x), 32'(mh));
            check_val("pixelY", 32'(pixel_y), 32'(mv));
            check_val("startOfFrame", 32'(sof), 32'(mh == 0 && mv == 0));
            if (q.size() > 0) begin
                e = q.pop_front();
                check_val("rgb", {8'h00, red, green, blue}, {8'h00, e.r, e.g, e.b});
                check_val("hSync", 32'(h_sync), 32'(e.hs));
                check_val("vSync", 32'(v_sync), 32'(e.vs));
                check_val("blankN", 32'(blank_n), 32'(e.bn));
`ifdef VGA_TEST_PATTERN_EN
                if (e.tm && e.v == 0 && e.h == 0)      check_val("tp_px0", {red, green, blue}, 24'hFFFFFF);
                if (e.tm && e.v == 0 && e.h == HA / 8) check_val("tp_bar1", {red, green, blue}, 24'hFFFF00);
                if (e.tm && e.v == 0 && e.h == HA - 1) check_val("tp_last", {red, green, blue}, 24'h000000);
`endif
            end else begin
                check_val("sb_underflow", 32'(q.size()), 32'd1);
            end
            if (prev_hs && !h_sync) check_val("hs_fall_x", 32'(pixel_x), 32'(HA + HF + 2));
            if (!prev_hs && h_sync && !reset) check_val("hs_rise_x", 32'(pixel_x), 32'(HA + HF + HS + 2));
            if (prev_vs && !v_sync) check_val("vs_fall_xy", {5'd0, pixel_y, 5'd0, pixel_x}, {5'd0, 11'(VA + VF), 16'd2});
            prev_hs = h_sync;
            prev_vs = v_sync;
            if (!v_sync) vs_low_cnt++;
            if (sof) sof_cnt++;
            if (red == 8'hFF && green == 8'h00 && blue == 8'h00) red_hit_cnt++;
            if (reset) begin
                last_h0 = -1;
                last_sof = -1;
            end else begin
                if (pixel_x == 11'd0) begin
                    if (last_h0 >= 0) check_val("h_period", 32'(cyc - last_h0), 32'(HT));
                    last_h0 = cyc;
                end
                if (sof) begin
                    if (last_sof >= 0) check_val("frame_period", 32'(cyc - last_sof), 32'(FT));
                    last_sof = cyc;
                end
            end
        end
        rgb_nx = pattern(mh);
        q.push_back(expect_px(mh, mv, rgb_nx, test_mode));
        reset = rst_next;
        @(posedge clk);
        if (rst_next) begin
            mh = 0; mv = 0;
            q.delete();
            q.push_back(idle_px());
            q.push_back(idle_px());
            armed = 1'b1;
        end else if (mh == HT - 1) begin
            mh = 0;
            mv = (mv == VT - 1) ? 0 : mv + 1;
        end else begin
            mh = mh + 1;
        end
        #1 rgb_in = rgb_nx;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_rgb"}, {red, green, blue}, 24'h000000);
        check_val({tag, "_sync"}, {h_sync, v_sync, blank_n}, 3'b110);
        check_val({tag, "_pos"}, {pixel_x, pixel_y, sof}, {11'd0, 11'd0, 1'b1});
    endtask

    initial begin
        reset = 1'b1;
        rgb_in = 8'h00;
        test_mode = 1'b0;
        repeat (3) cycle(1'b1);
        check_reset_outputs("reset_state");

        // Constant white: blanking, sync counts, one startOfFrame per frame.
        mode = 0; vs_low_cnt = 0; sof_cnt = 0;
        repeat (FT) cycle(1'b0);
        check_val("vs_low_clks", 32'(vs_low_cnt), 32'(VS * HT));
        check_val("sof_per_frame", 32'(sof_cnt), 32'd1);

        // Single red pixel at x==10 on every line.
        mode = 1; red_hit_cnt = 0;
        repeat (FT) cycle(1'b0);
        check_val("red_hits", 32'(red_hit_cnt), 32'(VA));

        mode = 2;
        repeat (FT) cycle(1'b0);
        test_mode = 1'b1;
        repeat (FT) cycle(1'b0);
        test_mode = 1'b0;

        // Reset mid-frame at (30,5) for 3 clocks.
        for (int i = 0; i < FT && !(mh == 30 && mv == 5); i++) cycle(1'b0);
        check_val("rst_point", 32'(mh == 30 && mv == 5), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1);
            check_reset_outputs("mid_reset");
        end
        reset = 1'b0;
        #1 check_val("post_rst_pos", {pixel_x, pixel_y, sof}, {11'd0, 11'd0, 1'b1});
        cycle(1'b0);
        check_val("post_rst_count", 32'(pixel_x), 32'd1);
        repeat (FT + 10) cycle(1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
